spi_slave_mem: RTL
==================

SPI_SLAVE_MEM -- requirements
Module: spi_slave_mem

Interface
REQ-001 Parameter DEPTH, default 16: number of 32-bit registers in the slave register file; power of two, 2 to 256.
REQ-002 Parameter CMD_WRITE, default 8'h69: write command byte.
REQ-003 Parameter CMD_READ, default 8'h00: read command byte.
REQ-004 Parameter SYNC_STAGES, default 2: synchronizer depth on sclk, cs_n and mosi.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 sclk  input  1  serial clock from the SPI master; idles high; asynchronous to clk.
REQ-008 cs_n  input  1  chip select, active low; asynchronous to clk.
REQ-009 mosi  input  1  serial data from the master.
REQ-010 miso  output  1  serial read data to the master.
REQ-011 wr_valid  output  1  one-clk pulse when a write frame commits.
REQ-012 wr_addr  output  $clog2(DEPTH)  register index of the committed write; valid with wr_valid.
REQ-013 wr_data  output  32  data of the committed write; valid with wr_valid.
REQ-014 busy  output  1  high while cs_n (synchronized) is low.
REQ-015 cmd_err  output  1  one-clk pulse when a header carries an unsupported command.

Function
REQ-016 sclk, cs_n and mosi SHALL each pass through SYNC_STAGES flops; edges SHALL be detected from the synchronized sclk against a one-cycle-delayed copy.
REQ-017 A legal sclk high or low phase SHALL last at least 4 clk cycles; behaviour for shorter phases is not specified.
REQ-018 mosi SHALL be sampled on each detected sclk rising edge; miso SHALL change only on detected sclk falling edges (CPOL=1, CPHA=1).
REQ-019 Frame format, LSB first: bits 0-7 command, bits 8-31 address, bits 32-63 data.
REQ-020 Register index SHALL be address[$clog2(DEPTH)-1:0]; higher address bits SHALL be ignored.
REQ-021 FSM states: IDLE, HEADER, WR_DATA, RD_DATA, IGNORE.
REQ-022 IDLE -> HEADER on a synchronized cs_n falling edge; the bit counter SHALL clear to 0.
REQ-023 HEADER -> WR_DATA, RD_DATA or IGNORE on the 32nd sampled bit, selected by command = CMD_WRITE, CMD_READ or other; "other" SHALL pulse cmd_err for one clk.
REQ-024 On entry to RD_DATA, mem[index] SHALL load into the transmit shift register; bit 0 SHALL drive miso on the next sclk falling edge, then one bit per falling edge.
REQ-025 WR_DATA: on the 32nd data bit, mem[index] SHALL be written, and wr_valid, wr_addr and wr_data SHALL be asserted in the clk cycle after that rising edge is detected; the state then goes to IGNORE.
REQ-026 RD_DATA -> IGNORE after 32 data bits; IGNORE SHALL discard further sclk edges.
REQ-027 A synchronized cs_n rising edge in any state SHALL force IDLE in the next cycle, with no write commit, and miso = 0.
REQ-028 cs_n rising in the same cycle as the 32nd write-data edge SHALL abort: no write, no wr_valid.
REQ-029 miso SHALL be 0 in every state except RD_DATA.
REQ-030 A read of an index written earlier in the same session SHALL return the new data.

Reset
REQ-031 rst SHALL asynchronously force state IDLE and clear the bit counter and shift registers, with miso=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0 and cmd_err=0.
REQ-032 All register-file entries SHALL reset to 32'h0; synchronizer flops SHALL reset to the idle levels sclk=1, cs_n=1, mosi=0.
REQ-033 rst mid-frame SHALL discard the frame; after rst releases, the next cs_n falling edge SHALL start a clean frame.

Structure
REQ-034 The FSM state enumeration and the default CMD_WRITE and CMD_READ values SHALL live in a shared package, spi_pkg, which the master also uses.
REQ-035 The synchronizer and edge detector SHALL be one sub-module, spi_sync_edge, instantiated three times.

Verification
REQ-036 Write frame cmd 8'h69, addr 24'h000003, data 32'hDEADBEEF -> single wr_valid pulse with wr_addr=3 and wr_data=32'hDEADBEEF; mem[3]=32'hDEADBEEF.
REQ-037 Read frame cmd 8'h00, addr 3 after REQ-036 -> miso shifts out 32'hDEADBEEF LSB first on falling edges; miso=0 outside the data phase.
REQ-038 Header cmd 8'hA5 -> one cmd_err pulse; no wr_valid; miso stays 0 for the whole frame.
REQ-039 Write frame with cs_n released after 20 data bits -> no wr_valid; mem unchanged; busy drops 2-3 clk after cs_n rises.
REQ-040 rst asserted mid write frame, then a fresh write of 32'h12345678 to addr 24'hFFFF05 (index 5 with DEPTH=16) -> all outputs 0 during rst; mem[5]=32'h12345678; other entries 0.

Source files
------------

// File: rtl/spi_pkg.sv
// +----------------------------------------------------------------------------+
// | spi_pkg: frame FSM states and default command bytes shared by SPI blocks   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_IGNORE  = 3'd4
    } spi_state_t;

    localparam logic [7:0] C_CMD_WRITE_DEF = 8'h69;
    localparam logic [7:0] C_CMD_READ_DEF  = 8'h00;
    localparam int         C_FRAME_WORD    = 32;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// +----------------------------------------------------------------------------+
// | spi_sync_edge: multi-flop synchronizer with rising/falling edge detect     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Reset to the line's idle level so no false edge appears after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

`default_nettype wire

// File: rtl/spi_slave_mem.sv
// +----------------------------------------------------------------------------+
// | spi_slave_mem: SPI (mode 3, LSB first) slave with 32-bit register file     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_slave_mem
    import spi_pkg::*;
#(
    parameter int         DEPTH       = 16,
    parameter logic [7:0] CMD_WRITE   = C_CMD_WRITE_DEF,
    parameter logic [7:0] CMD_READ    = C_CMD_READ_DEF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sclk,
    input  logic                     cs_n,
    input  logic                     mosi,
    output logic                     miso,
    output logic                     wr_valid,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [31:0]              wr_data,
    output logic                     busy,
    output logic                     cmd_err
);

    localparam int AW = $clog2(DEPTH);

    logic w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic w_cs_q, w_cs_rise, w_cs_fall;
    logic w_mosi_q, w_mosi_rise, w_mosi_fall;
    logic [2:0] w_unused_bits;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_d(sclk),
        .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .i_d(cs_n),
        .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .i_d(mosi),
        .o_q(w_mosi_q), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused_bits = {w_sclk_q, w_mosi_rise, w_mosi_fall};

    spi_state_t      r_state, w_next;
    logic [4:0]      r_bitcnt;
    logic [31:0]     r_sr, r_tx;
    logic [AW-1:0]   r_idx;
    logic            r_miso, r_wr_valid, r_cmd_err;
    logic [AW-1:0]   r_wr_addr;
    logic [31:0]     r_wr_data;
    logic [31:0]     r_mem [DEPTH];

    logic            w_last_bit, w_commit, w_cmd_bad, w_shifting;
    logic [31:0]     w_shift_in;
    logic [AW-1:0]   w_hdr_idx;

    // Bits arrive LSB first, so each new bit enters at the top of the word
    assign w_shift_in = {w_mosi_q, r_sr[31:1]};
    assign w_hdr_idx  = w_shift_in[8 +: AW];
    assign w_shifting = (r_state == ST_HEADER) || (r_state == ST_WR_DATA) ||
                        (r_state == ST_RD_DATA);
    assign w_last_bit = w_sclk_rise && (r_bitcnt == 5'd31);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_commit  = 1'b0;
        w_cmd_bad = 1'b0;
        if (w_cs_rise) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_cs_fall) w_next = ST_HEADER;
                ST_HEADER: begin
                    if (w_last_bit) begin
                        if (w_shift_in[7:0] == CMD_WRITE)     w_next = ST_WR_DATA;
                        else if (w_shift_in[7:0] == CMD_READ) w_next = ST_RD_DATA;
                        else begin
                            w_next    = ST_IGNORE;
                            w_cmd_bad = 1'b1;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (w_last_bit) begin
                        w_next   = ST_IGNORE;
                        w_commit = 1'b1;
                    end
                end
                ST_RD_DATA: if (w_last_bit) w_next = ST_IGNORE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bitcnt   <= '0;
            r_sr       <= '0;
            r_tx       <= '0;
            r_idx      <= '0;
            r_miso     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_cmd_err  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_wr_valid <= w_commit;
            r_cmd_err  <= w_cmd_bad;
            if (w_commit) begin
                r_mem[r_idx] <= w_shift_in;
                r_wr_addr    <= r_idx;
                r_wr_data    <= w_shift_in;
            end
            if (r_state == ST_IDLE) r_bitcnt <= '0;
            else if (w_shifting && w_sclk_rise) r_bitcnt <= r_bitcnt + 5'd1;
            if (w_shifting && w_sclk_rise) r_sr <= w_shift_in;
            if (r_state == ST_HEADER && w_last_bit) r_idx <= w_hdr_idx;
            // Load reads the array after any same-session write has landed
            if (r_state == ST_HEADER && w_next == ST_RD_DATA) r_tx <= r_mem[w_hdr_idx];
            else if (r_state == ST_RD_DATA && w_sclk_fall)  r_tx <= {1'b0, r_tx[31:1]};
            if (w_next != ST_RD_DATA) r_miso <= 1'b0;
            else if (r_state == ST_RD_DATA && w_sclk_fall) r_miso <= r_tx[0];
        end
    end

    assign miso     = r_miso;
    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign cmd_err  = r_cmd_err;
    assign busy     = ~w_cs_q;

endmodule

`default_nettype wire
